// File: rtl/seq_gen_if.sv
// Handshake and serial-output bundle for seq_gen.
interface seq_gen_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             out_bit;
  logic             out_valid;
  logic             done;

  modport master (output load, data_in, input ready, out_bit, out_valid, done);
  modport slave  (input load, data_in, output ready, out_bit, out_valid, done);
endinterface

// File: rtl/seq_gen.sv
// Serial frame transmitter: preamble, MSB-first payload, optional even parity.
// Define SEQ_GEN_PARITY_EN to append the parity bit (adds the PAR state).
module seq_gen #(
  parameter int                 WIDTH    = 8,
  parameter int                 PRE_LEN  = 3,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 3'b101
) (
  input  logic      clock,
  input  logic      reset,
  seq_gen_if.slave  bus
);
  localparam int CW = $clog2(PRE_LEN + WIDTH + 2);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
`ifdef SEQ_GEN_PARITY_EN
    DATA,
    PAR
`else
    DATA
`endif
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [WIDTH-1:0]   shreg, shreg_n;
  logic [PRE_LEN-1:0] pre_sr, pre_sr_n;
  logic               ready_q, ready_n;
  logic               out_bit_q, out_bit_n;
  logic               out_valid_q, out_valid_n;
  logic               done_q, done_n;
`ifdef SEQ_GEN_PARITY_EN
  logic               par, par_n;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      pre_sr      <= '0;
      ready_q     <= 1'b1;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      pre_sr      <= pre_sr_n;
      ready_q     <= ready_n;
      out_bit_q   <= out_bit_n;
      out_valid_q <= out_valid_n;
      done_q      <= done_n;
`ifdef SEQ_GEN_PARITY_EN
      par         <= par_n;
`endif
    end
  end

  // Outputs are computed one cycle ahead: state names the bit currently on the line.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    pre_sr_n    = pre_sr;
    ready_n     = ready_q;
    out_bit_n   = out_bit_q;
    out_valid_n = out_valid_q;
    done_n      = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_n       = par;
`endif
    case (state)
      IDLE: begin
        ready_n     = 1'b1;
        out_bit_n   = 1'b0;
        out_valid_n = 1'b0;
        if (bus.load) begin
          shreg_n     = bus.data_in;
`ifdef SEQ_GEN_PARITY_EN
          par_n       = ^bus.data_in;
`endif
          state_n     = PRE;
          cnt_n       = '0;
          ready_n     = 1'b0;
          out_valid_n = 1'b1;
          out_bit_n   = PREAMBLE[PRE_LEN-1];
          pre_sr_n    = PREAMBLE << 1;
        end
      end
      PRE: begin
        if (cnt == CW'(PRE_LEN - 1)) begin
          state_n   = DATA;
          cnt_n     = '0;
          out_bit_n = shreg[WIDTH-1];
          shreg_n   = shreg << 1;
        end else begin
          cnt_n     = cnt + 1'b1;
          out_bit_n = pre_sr[PRE_LEN-1];
          pre_sr_n  = pre_sr << 1;
        end
      end
      DATA: begin
        if (cnt == CW'(WIDTH - 1)) begin
          cnt_n = '0;
`ifdef SEQ_GEN_PARITY_EN
          state_n   = PAR;
          out_bit_n = par;
`else
          state_n     = IDLE;
          out_bit_n   = 1'b0;
          out_valid_n = 1'b0;
          done_n      = 1'b1;
          ready_n     = 1'b1;
`endif
        end else begin
          cnt_n     = cnt + 1'b1;
          out_bit_n = shreg[WIDTH-1];
          shreg_n   = shreg << 1;
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR: begin
        state_n     = IDLE;
        out_bit_n   = 1'b0;
        out_valid_n = 1'b0;
        done_n      = 1'b1;
        ready_n     = 1'b1;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready     = ready_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen; frame length and parity follow SEQ_GEN_PARITY_EN.
module tb_seq_gen;
  localparam int W = 8;
`ifdef SEQ_GEN_PARITY_EN
  localparam int FL = 12;
`else
  localparam int FL = 11;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  seq_gen_if #(.WIDTH(W)) bus();
  seq_gen #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [FL-1:0] exp_frame(input logic [W-1:0] d);
`ifdef SEQ_GEN_PARITY_EN
    return {3'b101, d, ^d};
`else
    return {3'b101, d};
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [W-1:0] d);
    bus.load    = 1'b1;
    bus.data_in = d;
    tick();
    bus.load    = 1'b0;
    bus.data_in = ~d;
  endtask

  // Samples one whole frame starting just after E0; optionally pulses load
  // so that it is sampled at edge E0+pk.
  task automatic collect(input int pk, input logic [W-1:0] pd,
                         output logic [FL-1:0] got, output int vcnt, output int ctl_bad);
    got = '0; vcnt = 0; ctl_bad = 0;
    for (int k = 0; k < FL; k++) begin
      got = {got[FL-2:0], bus.out_bit};
      if (bus.out_valid === 1'b1) vcnt++;
      if (bus.ready !== 1'b0 || bus.done !== 1'b0) ctl_bad++;
      if (k == pk - 1) begin
        bus.load = 1'b1; bus.data_in = pd;
      end else begin
        bus.load = 1'b0;
      end
      tick();
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.data_in = '0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_cmp++; if (bus.out_bit !== 1'b0) begin n_fail++; $display("FAIL reset_out_bit: got %b want 0", bus.out_bit); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
  endtask

  task automatic test_frame(input logic [W-1:0] d);
    logic [FL-1:0] got;
    int vcnt, bad;
    start(d);
    collect(-1, '0, got, vcnt, bad);
    n_cmp++; if (got !== exp_frame(d)) begin n_fail++; $display("FAIL frame_%h_bits: got %b want %b", d, got, exp_frame(d)); end
    n_cmp++; if (vcnt != FL) begin n_fail++; $display("FAIL frame_%h_valid_cycles: got %0d want %0d", d, vcnt, FL); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL frame_%h_ctl_in_frame: got %0d bad cycles want 0", d, bad); end
    n_cmp++; if ({bus.out_valid, bus.out_bit, bus.done, bus.ready} !== 4'b0011)
      begin n_fail++; $display("FAIL frame_%h_end: got v/b/d/r=%b want 0011", d, {bus.out_valid, bus.out_bit, bus.done, bus.ready}); end
    tick();
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL frame_%h_done_width: got %b want 0", d, bus.done); end
  endtask

  task automatic test_basic();
    test_frame(8'hA5);
  endtask

  task automatic test_parity();
    test_frame(8'h01);
    test_frame(8'hFF);
  endtask

  task automatic test_ignored_load();
    logic [FL-1:0] got;
    int vcnt, bad, extra;
    start(8'h3C);
    collect(4, 8'hFF, got, vcnt, bad);
    n_cmp++; if (got !== exp_frame(8'h3C)) begin n_fail++; $display("FAIL ignored_load_bits: got %b want %b", got, exp_frame(8'h3C)); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL ignored_load_ready: got %0d bad cycles want 0", bad); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ignored_load_done: got %b want 1", bus.done); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) extra++;
    end
    n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL ignored_load_no_second: got %0d valid cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    start(8'hA5);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({bus.out_valid, bus.out_bit, bus.ready, bus.done} !== 4'b0010)
      begin n_fail++; $display("FAIL reset_mid_state: got v/b/r/d=%b want 0010", {bus.out_valid, bus.out_bit, bus.ready, bus.done}); end
    reset = 1'b1; bus.load = 1'b1; bus.data_in = 8'hFF;
    tick();
    reset = 1'b0; bus.load = 1'b0;
    tick();
    n_cmp++; if ({bus.out_valid, bus.ready} !== 2'b01)
      begin n_fail++; $display("FAIL reset_load_same_edge: got v/r=%b want 01", {bus.out_valid, bus.ready}); end
    test_frame(8'h5A);
  endtask

  task automatic test_back_to_back();
    logic [FL-1:0] got1, got2;
    int v1, v2, b1, b2;
    start(8'h80);
    collect(-1, '0, got1, v1, b1);
    n_cmp++; if ({bus.done, bus.out_bit, bus.ready} !== 3'b101)
      begin n_fail++; $display("FAIL b2b_gap: got d/b/r=%b want 101", {bus.done, bus.out_bit, bus.ready}); end
    start(8'h01);
    collect(-1, '0, got2, v2, b2);
    n_cmp++; if (got1 !== exp_frame(8'h80)) begin n_fail++; $display("FAIL b2b_first: got %b want %b", got1, exp_frame(8'h80)); end
    n_cmp++; if (got2 !== exp_frame(8'h01) || v2 != FL) begin n_fail++; $display("FAIL b2b_second: got %b/%0d want %b/%0d", got2, v2, exp_frame(8'h01), FL); end
    tick();
  endtask

  // Overlapping 101 detector on the line, as the receiver sees it.
  task automatic test_detect();
    logic [2:0] win;
    int hits, first;
    win = '0; hits = 0; first = -1;
    start(8'h00);
    for (int k = 0; k < FL; k++) begin
      win = {win[1:0], bus.out_bit};
      if (win == 3'b101) begin
        hits++;
        if (first < 0) first = k;
      end
      tick();
    end
    n_cmp++; if (first != 2) begin n_fail++; $display("FAIL detect_first: got %0d want 2", first); end
    n_cmp++; if (hits != 1) begin n_fail++; $display("FAIL detect_count: got %0d want 1", hits); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_ignored_load();
    test_reset_mid();
    test_back_to_back();
    test_detect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_gen.md
# seq_gen

Serial frame transmitter for the bit-serial link whose receive side is the `seq_det` pattern detector. Accepts a parallel word through a load/ready handshake. Emits it one bit per clock, MSB first, behind a fixed `101` preamble that the detector locks onto. Optionally appends an even-parity bit. Sits between the stimulus/control logic and the serial input (`inp`) of the detector.

## Interface

Parameters:
- `WIDTH`, 8: payload bits per frame (≥ 1).
- `PREAMBLE`, 3'b101: preamble pattern, sent MSB first.
- `PRE_LEN`, 3: preamble length in bits (≥ 1); `PREAMBLE` is `PRE_LEN` bits wide.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `load`  in  1  request to start a frame with `data_in`.
- `data_in`  in  WIDTH  payload word, sampled when `load && ready`.
- `ready`  out  1  high when a new `load` will be accepted.
- `out_bit`  out  1  serial data; drives the detector's `inp`.
- `out_valid`  out  1  high while `out_bit` carries a frame bit.
- `done`  out  1  one-cycle pulse after the last frame bit.

## Operation

- States: IDLE, PRE, DATA, PAR (PAR exists only with the parity macro).
- All outputs are registered.
- Reset values: `ready`=1, `out_bit`=0, `out_valid`=0, `done`=0; state IDLE; shift register and bit counter cleared.
- IDLE:
  - `out_bit`=0 (idle line level), `out_valid`=0, `ready`=1.
  - `load`=1 captures `data_in` into the shift register. Parity is computed from the captured word.
  - Go to PRE with counter=0.
- PRE: drive `PREAMBLE[PRE_LEN-1-cnt]`. After `PRE_LEN` bits, go to DATA.
- DATA:
  - Drive the shift register MSB, then shift left by one each cycle.
  - After `WIDTH` bits, go to PAR if enabled, otherwise IDLE.
- PAR: drive the XOR of all captured payload bits (even parity) for one cycle, then go to IDLE.
- Frame length L = `PRE_LEN` + `WIDTH` (+1 with parity).
- `load` while `ready`=0 is ignored. The frame in flight is unaffected and the request is not queued.
- `data_in` changes after capture have no effect.
- `reset` has priority over every other input, in any state, including mid-frame:
  - The next cycle shows reset values.
  - The partial frame is discarded.
  - `done` is not pulsed.
- Counter width is `$clog2(PRE_LEN+WIDTH+2)`. No wrap-around occurs within a frame.

## Timing

- Let E0 be the rising edge at which `load && ready` is sampled.
- After E0: `ready`=0, `out_valid`=1, `out_bit` = frame bit 0. There is one cycle of latency from load to first bit.
- After edge E0+k (0 ≤ k < L): `out_bit` = frame bit k. Exactly one bit per clock, no stalls.
- After E0+L:
  - `out_valid`=0, `out_bit`=0.
  - `done`=1 for exactly one cycle.
  - `ready`=1.
- `load` is accepted in the `done` cycle. The next frame's bit 0 appears after E0+L+1, so back-to-back frames have exactly one idle (0) bit between them.
- `load` and `reset` high at the same edge: reset wins and nothing is captured.

## Configuration

- `SEQ_GEN_PARITY_EN`
  - Defined: the PAR state exists; L = `PRE_LEN`+`WIDTH`+1; the final bit is even parity over the payload.
  - Undefined: no PAR state; L = `PRE_LEN`+`WIDTH`; `done` follows the last payload bit.
- All other behaviour is identical in both builds.

## Test plan

- Reset, then `load` 8'hA5 with defaults and no macro:
  - `out_bit` after E0..E0+10 = 1,0,1,1,0,1,0,0,1,0,1.
  - `out_valid` is high for exactly 11 cycles.
  - `done` pulses once after E0+11, with `ready`=1.
- With `SEQ_GEN_PARITY_EN`:
  - 8'hA5 gives 12 bits, the last one 0.
  - 8'h01 gives 12 bits ending 0,0,0,0,0,0,0,1,1.
  - `done` is delayed by one cycle relative to the no-macro build.
- `load` pulsed with 8'hFF at E0+4 while sending 8'h3C: the 8'h3C frame is bit-exact, no second frame follows, and `ready` stays 0 until `done`.
- `reset` asserted for one cycle at E0+6 of an 8'hA5 frame:
  - The next cycle has `out_valid`=0, `out_bit`=0, `ready`=1, `done`=0.
  - A new `load` of 8'h5A then produces a complete, correct frame.
- Back-to-back loads of 8'h80 then 8'h01, the second issued in the `done` cycle: exactly one 0 idle bit separates the frames.
- Connect `out_bit` to `seq_det`'s `inp` and send 8'h00: `result` asserts on the third preamble bit and on no payload bit.
